// File: rtl/coin_validator.sv
// coin_validator: front end between two raw coin sensors and the vending FSM.
// Each sensor is synchronized and debounced. A debounced rising edge is a coin
// event, and events become one-cycle coin pulses spaced by at least GAP idle
// cycles. Simultaneous events on both channels are reported as a jam. A sensor
// stuck high latches a fault until reset.
//
// Ports:
//   clk     in   single clock, rising edge
//   rst     in   asynchronous active-high reset
//   ena     in   design enable; 0 holds all state and masks the coin pulses
//   sense1  in   raw 1-rupee sensor (asynchronous, bouncy)
//   sense2  in   raw 2-rupee sensor (asynchronous, bouncy)
//   coinx   out  one-cycle pulse per accepted 1-rupee coin
//   coiny   out  one-cycle pulse per accepted 2-rupee coin
//   jam     out  level, both channels rose together and have not yet cleared
//   fault   out  sticky level, a sensor stayed high too long
module coin_validator #(
    parameter int unsigned DEBOUNCE = 8,
    parameter int unsigned GAP      = 4,
    parameter int unsigned STUCK    = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic sense1,
    input  logic sense2,
    output logic coinx,
    output logic coiny,
    output logic jam,
    output logic fault
);

    typedef enum logic [2:0] {StIdle, StEmit, StHold, StJam, StFault} state_e;

    localparam logic [7:0] DebLast  = 8'(DEBOUNCE - 1);
    localparam logic [9:0] StuckMax = 10'(STUCK);
    localparam logic [3:0] GapLoad  = 4'(GAP);

    // Bit 0 is the 1-rupee channel, bit 1 the 2-rupee channel.
    logic [1:0]       meta_q, meta_d, sync_q, sync_d, deb_q, deb_d;
    logic [1:0][7:0]  cnt_q, cnt_d;
    logic [1:0][9:0]  stuck_q, stuck_d;
    logic [1:0]       pend_q, pend_d;
    logic [1:0]       rise;
    logic             stuck_hit;
    state_e           state_q, state_d;
    logic [3:0]       gap_q, gap_d;
    logic             coinx_q, coinx_d, coiny_q, coiny_d;

    // Synchronizer, debounce and stuck-high counting.
    always_comb begin
        meta_d  = meta_q;
        sync_d  = sync_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        stuck_d = stuck_q;
        rise    = 2'b00;
        if (ena) begin
            meta_d = {sense2, sense1};
            sync_d = meta_q;
            for (int c = 0; c < 2; c++) begin
                if (sync_q[c] != deb_q[c]) begin
                    if (cnt_q[c] == DebLast) begin
                        deb_d[c] = sync_q[c];
                        cnt_d[c] = 8'd0;
                        rise[c]  = sync_q[c];
                    end else begin
                        cnt_d[c] = cnt_q[c] + 8'd1;
                    end
                end else begin
                    cnt_d[c] = 8'd0;
                end
                if (!deb_q[c]) begin
                    stuck_d[c] = 10'd0;
                end else if (stuck_q[c] != StuckMax) begin
                    stuck_d[c] = stuck_q[c] + 10'd1;
                end
            end
        end
    end

    assign stuck_hit = (stuck_q[0] == StuckMax) || (stuck_q[1] == StuckMax);

    // Controller: fault beats jam beats normal pulse scheduling.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        pend_d  = pend_q;
        coinx_d = coinx_q;
        coiny_d = coiny_q;
        if (ena) begin
            coinx_d = 1'b0;
            coiny_d = 1'b0;
            pend_d  = pend_q | rise;
            if (state_q == StFault) begin
                pend_d = 2'b00;
            end else if (stuck_hit) begin
                state_d = StFault;
                pend_d  = 2'b00;
            end else if (state_q == StJam) begin
                pend_d = 2'b00;
                if (deb_q == 2'b00) begin
                    state_d = StIdle;
                end
            end else if (rise == 2'b11) begin
                state_d = StJam;
                pend_d  = 2'b00;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (pend_q[0]) begin
                            state_d   = StEmit;
                            coinx_d   = 1'b1;
                            pend_d[0] = rise[0];
                        end else if (pend_q[1]) begin
                            state_d   = StEmit;
                            coiny_d   = 1'b1;
                            pend_d[1] = rise[1];
                        end
                    end
                    StEmit: begin
                        state_d = StHold;
                        gap_d   = GapLoad;
                    end
                    StHold: begin
                        // gap_q counts idle cycles still owed after the pulse.
                        // The IDLE->EMIT hop supplies the last one, so leave
                        // with two (or fewer, for GAP=1) still owed.
                        if (gap_q != 4'd0) begin
                            gap_d = gap_q - 4'd1;
                        end
                        if (gap_q <= 4'd2) begin
                            state_d = StIdle;
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= 2'b00;
            sync_q  <= 2'b00;
            deb_q   <= 2'b00;
            cnt_q   <= '0;
            stuck_q <= '0;
            pend_q  <= 2'b00;
            state_q <= StIdle;
            gap_q   <= 4'd0;
            coinx_q <= 1'b0;
            coiny_q <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            stuck_q <= stuck_d;
            pend_q  <= pend_d;
            state_q <= state_d;
            gap_q   <= gap_d;
            coinx_q <= coinx_d;
            coiny_q <= coiny_d;
        end
    end

    // A pulse held across ena=0 stays registered and shows once ena returns.
    assign coinx = coinx_q & ena;
    assign coiny = coiny_q & ena;
    assign jam   = (state_q == StJam);
    assign fault = (state_q == StFault);

endmodule
